// File: rtl/chiplib_riscv_plic_pkg.sv
// Shared PLIC definitions.
//   plic_claim_state_e : claim/complete controller state (SETTLE, READY).
//   PlicNoIrq          : the reserved "no interrupt" ID returned by an empty claim.
package chiplib_riscv_plic_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    READY  = 1'b1
  } plic_claim_state_e;

  localparam int unsigned PlicNoIrq = 0;

endpackage : chiplib_riscv_plic_pkg

// File: rtl/chiplib_riscv_plic_claim_ctrl.sv
// Per-target PLIC claim/complete controller.
//
// Sequences hart claims and completions against the target's pipelined
// priority arbiter. It drives the gateway pending-clear (gw_claim) and
// re-arm (gw_cmpl) pulses. It also holds the target interrupt low while the
// arbiter output is stale, so a hart never claims an ID that was already
// cleared or reconfigured.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   arb_irq           arbiter grant-valid
//   arb_claim_id      arbiter winning ID
//   cfg_chg           pulse: enable/threshold/priority of this target written
//   claim_valid       claim read request (held until claim_ready)
//   claim_ready       claim accepted this cycle
//   claim_rsp_valid   one-cycle claim response, cycle after accept
//   claim_rsp_id      claimed ID, or 0
//   cmpl_valid        completion write, always accepted
//   cmpl_id           completed ID
//   gw_claim/_id      pulse: gateway clears pending of gw_claim_id
//   gw_cmpl/_id       pulse: gateway re-arms gw_cmpl_id
//   irq_out           external interrupt line to the hart
//   dbg_state         current controller state
//
// Handshake: a claim transfers in a cycle where claim_valid && claim_ready.
// The requester keeps claim_valid high until then. claim_ready is only ever
// high in READY and never depends on claim_ready itself. The response
// appears exactly one cycle after the transfer.
module chiplib_riscv_plic_claim_ctrl
  import chiplib_riscv_plic_pkg::*;
#(
  parameter  int unsigned NumSources   = 100,
  parameter  int unsigned SettleCycles = 3,
  localparam int unsigned IdWidth      = $clog2(NumSources)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arb_irq,
  input  logic [IdWidth-1:0] arb_claim_id,
  input  logic               cfg_chg,
  input  logic               claim_valid,
  output logic               claim_ready,
  output logic               claim_rsp_valid,
  output logic [IdWidth-1:0] claim_rsp_id,
  input  logic               cmpl_valid,
  input  logic [IdWidth-1:0] cmpl_id,
  output logic               gw_claim,
  output logic [IdWidth-1:0] gw_claim_id,
  output logic               gw_cmpl,
  output logic [IdWidth-1:0] gw_cmpl_id,
  output logic               irq_out,
  output plic_claim_state_e  dbg_state
);

  localparam int unsigned      CntWidth = $clog2(SettleCycles + 1);
  localparam logic [IdWidth:0] NumSrcW  = (IdWidth + 1)'(NumSources);
  localparam logic [IdWidth-1:0] NoIrq  = IdWidth'(PlicNoIrq);

  plic_claim_state_e      state_q;
  logic [CntWidth-1:0]    cnt_q;
  logic [NumSources-1:0]  claimed_q;
  logic [NumSources-1:0]  claimed_d;

  logic                   rsp_valid_q;
  logic [IdWidth-1:0]     rsp_id_q;
  logic                   gw_claim_q;
  logic [IdWidth-1:0]     gw_claim_id_q;
  logic                   gw_cmpl_q;
  logic [IdWidth-1:0]     gw_cmpl_id_q;

  // Holds a re-arm that must trail a same-cycle claim pulse of the same ID.
  logic                   defer_q;
  logic [IdWidth-1:0]     defer_id_q;

  logic                   claim_acc;
  logic [IdWidth-1:0]     claim_id;
  logic                   claim_nz;
  logic                   cmpl_in_range;
  logic                   cmpl_hit;
  logic                   same_id;
  logic                   cmpl_direct;
  logic                   restart;

  always_comb begin
    claim_acc     = (state_q == READY) && claim_valid;
    claim_id      = arb_irq ? arb_claim_id : NoIrq;
    claim_nz      = claim_acc && (claim_id != NoIrq);
    // Out-of-range and ID-0 completions never touch the bitmap.
    cmpl_in_range = ({1'b0, cmpl_id} < NumSrcW) && (cmpl_id != NoIrq);
    cmpl_hit      = cmpl_valid && cmpl_in_range && claimed_q[cmpl_id];
    // Completing the ID being claimed this cycle retires the earlier claim;
    // its re-arm must follow the new claim's pending-clear.
    same_id       = claim_nz && cmpl_hit && (claim_id == cmpl_id);
    cmpl_direct   = cmpl_hit && !same_id;
    restart       = cfg_chg || claim_nz || cmpl_hit;

    claimed_d = claimed_q;
    if (cmpl_hit) claimed_d[cmpl_id] = 1'b0;
    // Set after clear so a same-ID claim/complete leaves the bit set.
    if (claim_nz) claimed_d[claim_id] = 1'b1;
    claimed_d[0] = 1'b0;
  end

  // Settle counter and FSM. cnt_q is non-zero exactly while in SETTLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SETTLE;
      cnt_q   <= CntWidth'(SettleCycles);
    end else if (restart) begin
      state_q <= SETTLE;
      cnt_q   <= CntWidth'(SettleCycles);
    end else if (state_q == SETTLE) begin
      if (cnt_q == CntWidth'(1)) begin
        state_q <= READY;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q - CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      claimed_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      gw_claim_q    <= 1'b0;
      gw_claim_id_q <= '0;
      gw_cmpl_q     <= 1'b0;
      gw_cmpl_id_q  <= '0;
      defer_q       <= 1'b0;
      defer_id_q    <= '0;
    end else begin
      claimed_q     <= claimed_d;
      rsp_valid_q   <= claim_acc;
      rsp_id_q      <= claim_acc ? claim_id : NoIrq;
      gw_claim_q    <= claim_nz;
      gw_claim_id_q <= claim_nz ? claim_id : NoIrq;
      // One-deep re-arm queue: a deferred re-arm goes out first and any
      // completion arriving in the same cycle takes its slot.
      if (defer_q) begin
        gw_cmpl_q    <= 1'b1;
        gw_cmpl_id_q <= defer_id_q;
        defer_q      <= cmpl_hit;
        defer_id_q   <= cmpl_hit ? cmpl_id : NoIrq;
      end else begin
        gw_cmpl_q    <= cmpl_direct;
        gw_cmpl_id_q <= cmpl_direct ? cmpl_id : NoIrq;
        defer_q      <= same_id;
        defer_id_q   <= same_id ? cmpl_id : NoIrq;
      end
    end
  end

  assign claim_ready     = claim_acc;
  assign claim_rsp_valid = rsp_valid_q;
  assign claim_rsp_id    = rsp_id_q;
  assign gw_claim        = gw_claim_q;
  assign gw_claim_id     = gw_claim_id_q;
  assign gw_cmpl         = gw_cmpl_q;
  assign gw_cmpl_id      = gw_cmpl_id_q;
  assign irq_out         = (state_q == READY) && arb_irq && (arb_claim_id != NoIrq);
  assign dbg_state       = state_q;

endmodule : chiplib_riscv_plic_claim_ctrl

// File: tb/tb_chiplib_riscv_plic_claim_ctrl.sv
module tb_chiplib_riscv_plic_claim_ctrl;
  import chiplib_riscv_plic_pkg::*;

  localparam int IdW = 7;

  logic           clk;
  logic           rst_n;
  logic           arb_irq;
  logic [IdW-1:0] arb_claim_id;
  logic           cfg_chg;
  logic           claim_valid;
  logic           claim_ready;
  logic           claim_rsp_valid;
  logic [IdW-1:0] claim_rsp_id;
  logic           cmpl_valid;
  logic [IdW-1:0] cmpl_id;
  logic           gw_claim;
  logic [IdW-1:0] gw_claim_id;
  logic           gw_cmpl;
  logic [IdW-1:0] gw_cmpl_id;
  logic           irq_out;
  plic_claim_state_e dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  chiplib_riscv_plic_claim_ctrl #(.NumSources(100), .SettleCycles(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .arb_irq         (arb_irq),
    .arb_claim_id    (arb_claim_id),
    .cfg_chg         (cfg_chg),
    .claim_valid     (claim_valid),
    .claim_ready     (claim_ready),
    .claim_rsp_valid (claim_rsp_valid),
    .claim_rsp_id    (claim_rsp_id),
    .cmpl_valid      (cmpl_valid),
    .cmpl_id         (cmpl_id),
    .gw_claim        (gw_claim),
    .gw_claim_id     (gw_claim_id),
    .gw_cmpl         (gw_cmpl),
    .gw_cmpl_id      (gw_cmpl_id),
    .irq_out         (irq_out),
    .dbg_state       (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge,
  // outputs are observed 3 time units after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks common to a settle cycle: interrupt masked, no claim taken.
  task automatic chk_masked(input string tag);
    chk({tag, "_irq"}, 32'(irq_out), 32'd0);
    chk({tag, "_ready"}, 32'(claim_ready), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; arb_irq = 1'b1; arb_claim_id = 7'd5; cfg_chg = 1'b0;
    claim_valid = 1'b0; cmpl_valid = 1'b0; cmpl_id = '0;

    // Reset values
    cyc(); cyc(); cyc();
    sample();
    chk("rst_state", 32'(dbg_state), 32'(SETTLE));
    chk("rst_irq", 32'(irq_out), 32'd0);
    chk("rst_ready", 32'(claim_ready), 32'd0);
    chk("rst_rsp_valid", 32'(claim_rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(claim_rsp_id), 32'd0);
    chk("rst_gw_claim", 32'(gw_claim), 32'd0);
    chk("rst_gw_claim_id", 32'(gw_claim_id), 32'd0);
    chk("rst_gw_cmpl", 32'(gw_cmpl), 32'd0);
    chk("rst_gw_cmpl_id", 32'(gw_cmpl_id), 32'd0);

    // Release with winner 5 and a claim already pending: 3 masked cycles.
    cyc(); rst_n = 1'b1; claim_valid = 1'b1;
    sample(); chk_masked("rel0");
    cyc(); sample(); chk_masked("rel1");
    cyc(); sample(); chk_masked("rel2");
    cyc(); sample();
    chk("rel3_irq", 32'(irq_out), 32'd1);
    chk("rel3_ready", 32'(claim_ready), 32'd1);

    // Response of claim 5, then second held claim 4 cycles after the first.
    cyc(); sample();
    chk("c1_rsp_valid", 32'(claim_rsp_valid), 32'd1);
    chk("c1_rsp_id", 32'(claim_rsp_id), 32'd5);
    chk("c1_gw_claim", 32'(gw_claim), 32'd1);
    chk("c1_gw_claim_id", 32'(gw_claim_id), 32'd5);
    chk_masked("c1_s1");
    cyc(); sample(); chk_masked("c1_s2");
    chk("c1_pulse_once", 32'(claim_rsp_valid), 32'd0);
    chk("c1_gw_once", 32'(gw_claim), 32'd0);
    cyc(); sample(); chk_masked("c1_s3");
    cyc(); sample();
    chk("c2_ready", 32'(claim_ready), 32'd1);
    cyc(); claim_valid = 1'b0; sample();
    chk("c2_rsp_id", 32'(claim_rsp_id), 32'd5);
    chk("c2_gw_claim", 32'(gw_claim), 32'd1);

    // Empty claim: ID 0, no gateway pulse, no settle.
    cyc(); cyc(); cyc();
    arb_irq = 1'b0; claim_valid = 1'b1;
    sample();
    chk("e_ready", 32'(claim_ready), 32'd1);
    chk("e_irq", 32'(irq_out), 32'd0);
    cyc(); sample();
    chk("e_rsp_valid", 32'(claim_rsp_valid), 32'd1);
    chk("e_rsp_id", 32'(claim_rsp_id), 32'd0);
    chk("e_gw_claim", 32'(gw_claim), 32'd0);
    chk("e_next_ready", 32'(claim_ready), 32'd1);
    cyc(); claim_valid = 1'b0; sample();
    chk("e_state", 32'(dbg_state), 32'(READY));

    // Complete 5: re-arm next cycle and settle.
    cyc(); cmpl_valid = 1'b1; cmpl_id = 7'd5; arb_irq = 1'b1; arb_claim_id = 7'd5;
    sample();
    chk("k_irq_before", 32'(irq_out), 32'd1);
    cyc(); cmpl_valid = 1'b0; sample();
    chk("k_gw_cmpl", 32'(gw_cmpl), 32'd1);
    chk("k_gw_cmpl_id", 32'(gw_cmpl_id), 32'd5);
    chk("k_state", 32'(dbg_state), 32'(SETTLE));
    chk_masked("k_s1");
    cyc(); sample(); chk_masked("k_s2");
    cyc(); sample(); chk_masked("k_s3");
    cyc(); sample();
    chk("k_irq_after", 32'(irq_out), 32'd1);
    // Repeat complete 5, then out-of-range 120: both ignored.
    cmpl_valid = 1'b1; cmpl_id = 7'd5;
    cyc(); cmpl_id = 7'd120; sample();
    chk("k2_gw_cmpl", 32'(gw_cmpl), 32'd0);
    chk("k2_irq", 32'(irq_out), 32'd1);
    cyc(); cmpl_valid = 1'b0; sample();
    chk("k3_gw_cmpl", 32'(gw_cmpl), 32'd0);
    chk("k3_irq", 32'(irq_out), 32'd1);

    // cfg_chg every other cycle for 10 cycles, claim pending from cycle 1.
    for (int i = 0; i < 10; i++) begin
      cyc();
      cfg_chg = (i % 2 == 0);
      if (i == 1) claim_valid = 1'b1;
      sample();
      if (i >= 1) chk_masked($sformatf("cfg%0d", i));
    end
    cyc(); cfg_chg = 1'b0; sample(); chk_masked("cfg10");
    cyc(); sample(); chk_masked("cfg11");
    cyc(); sample();
    chk("cfg12_irq", 32'(irq_out), 32'd1);
    chk("cfg12_ready", 32'(claim_ready), 32'd1);
    cyc(); arb_claim_id = 7'd3; sample();
    chk("cfg13_rsp_id", 32'(claim_rsp_id), 32'd5);

    // Claim 3 (held through settle).
    cyc(); cyc(); cyc(); sample();
    chk("c3_ready", 32'(claim_ready), 32'd1);
    cyc(); claim_valid = 1'b0; sample();
    chk("c3_gw_claim_id", 32'(gw_claim_id), 32'd3);

    // Same-cycle claim of 7 and completion of 3.
    cyc(); cyc();
    cyc(); arb_claim_id = 7'd7; claim_valid = 1'b1; cmpl_valid = 1'b1; cmpl_id = 7'd3;
    sample();
    chk("x_ready", 32'(claim_ready), 32'd1);
    cyc(); claim_valid = 1'b0; cmpl_valid = 1'b0; sample();
    chk("x_gw_claim", 32'(gw_claim), 32'd1);
    chk("x_gw_claim_id", 32'(gw_claim_id), 32'd7);
    chk("x_gw_cmpl", 32'(gw_cmpl), 32'd1);
    chk("x_gw_cmpl_id", 32'(gw_cmpl_id), 32'd3);
    chk("x_rsp_id", 32'(claim_rsp_id), 32'd7);
    chk_masked("x_s1");
    cyc(); sample(); chk_masked("x_s2");
    cyc(); sample(); chk_masked("x_s3");
    cyc(); cmpl_valid = 1'b1; cmpl_id = 7'd3; sample();
    chk("x_irq_after", 32'(irq_out), 32'd1);
    cyc(); cmpl_id = 7'd7; sample();
    chk("x_bit3_clear", 32'(gw_cmpl), 32'd0);
    cyc(); cmpl_valid = 1'b0; sample();
    chk("x_bit7_set", 32'(gw_cmpl), 32'd1);
    chk("x_bit7_id", 32'(gw_cmpl_id), 32'd7);

    // Same-ID claim and completion of 5: re-arm trails the claim pulse.
    arb_claim_id = 7'd5;
    cyc(); cyc();
    cyc(); claim_valid = 1'b1; cmpl_valid = 1'b1; cmpl_id = 7'd5; sample();
    chk("s_ready", 32'(claim_ready), 32'd1);
    cyc(); claim_valid = 1'b0; cmpl_valid = 1'b0; sample();
    chk("s_gw_claim", 32'(gw_claim), 32'd1);
    chk("s_gw_claim_id", 32'(gw_claim_id), 32'd5);
    chk("s_gw_cmpl_early", 32'(gw_cmpl), 32'd0);
    cyc(); sample();
    chk("s_gw_cmpl", 32'(gw_cmpl), 32'd1);
    chk("s_gw_cmpl_id", 32'(gw_cmpl_id), 32'd5);
    cyc(); sample(); chk_masked("s_s3");
    cyc(); cmpl_valid = 1'b1; cmpl_id = 7'd5; sample();
    chk("s_ready_state", 32'(dbg_state), 32'(READY));
    cyc(); cmpl_valid = 1'b0; sample();
    chk("s_bit_kept", 32'(gw_cmpl), 32'd1);

    // Reset in the cycle a claim is accepted: pulses dropped, bitmap cleared.
    cyc(); cyc();
    cyc(); claim_valid = 1'b1; rst_n = 1'b0; sample();
    chk("r_ready", 32'(claim_ready), 32'd1);
    cyc(); claim_valid = 1'b0; rst_n = 1'b1; sample();
    chk("r_rsp_valid", 32'(claim_rsp_valid), 32'd0);
    chk("r_gw_claim", 32'(gw_claim), 32'd0);
    chk("r_state", 32'(dbg_state), 32'(SETTLE));
    cyc(); cyc();
    cyc(); cmpl_valid = 1'b1; cmpl_id = 7'd5; sample();
    chk("r_irq", 32'(irq_out), 32'd1);
    cyc(); cmpl_valid = 1'b0; sample();
    chk("r_bitmap_clear", 32'(gw_cmpl), 32'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_chiplib_riscv_plic_claim_ctrl
